// File: rtl/usbf_dma_arb_pkg.sv
// ----------------------------------------------------------------------------
// usbf_dma_pkg
// Shared definitions for the USB function DMA request arbiter:
//   - state_t     : arbiter FSM encoding (IDLE, XFER, GAP1, GAP2)
//   - DEF_*       : default values for the arbiter parameters
//   - to_width()  : width of the optional timeout counter for a given limit
// ----------------------------------------------------------------------------
package usbf_dma_pkg;

    localparam int DEF_NUM_EP    = 16;
    localparam int DEF_EPW       = 4;
    localparam int DEF_BURST_MAX = 4;
    localparam int DEF_TO_CYC    = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP1 = 2'd2,
        GAP2 = 2'd3
    } state_t;

    // One extra bit so the counter can hold TO_CYC-1 for any TO_CYC.
    function automatic int to_width(input int cyc);
        return $clog2(cyc) + 1;
    endfunction

endpackage

// File: rtl/usbf_dma_arb_if.sv
// ----------------------------------------------------------------------------
// usbf_dma_arb_if
// Bundle of the arbiter's endpoint-side and DMA-controller-side signals.
//   arb_en    : arbitration enable
//   dma_req   : per-endpoint request levels
//   dma_ack   : one-hot single-cycle word acknowledge to the endpoints
//   xfer_req  : word-transfer request to the system DMA controller
//   xfer_ep   : endpoint index of the current transfer
//   xfer_ack  : single-cycle word-complete from the DMA controller
//   dma_busy  : arbiter not idle
//   to_clr    : clear for the sticky timeout flag
//   to_err    : sticky timeout flag
// Modports:
//   master : the arbiter side
//   slave  : the environment (endpoints + DMA controller) side
// ----------------------------------------------------------------------------
import usbf_dma_pkg::*;

interface usbf_dma_arb_if #(
    parameter int NUM_EP = DEF_NUM_EP,
    parameter int EPW    = DEF_EPW
) ();
    logic              arb_en;
    logic [NUM_EP-1:0] dma_req;
    logic [NUM_EP-1:0] dma_ack;
    logic              xfer_req;
    logic [EPW-1:0]    xfer_ep;
    logic              xfer_ack;
    logic              dma_busy;
    logic              to_clr;
    logic              to_err;

    modport master (
        input  arb_en, dma_req, xfer_ack, to_clr,
        output dma_ack, xfer_req, xfer_ep, dma_busy, to_err
    );

    modport slave (
        output arb_en, dma_req, xfer_ack, to_clr,
        input  dma_ack, xfer_req, xfer_ep, dma_busy, to_err
    );
endinterface

// File: rtl/usbf_dma_arb_rr_pick.sv
// ----------------------------------------------------------------------------
// usbf_rr_pick
// Combinational round-robin picker. Searches req upward starting at ptr+1,
// wrapping modulo NUM_EP, and returns the first set position.
//   req   : request vector
//   ptr   : last granted index (search starts just above it)
//   valid : at least one request is set
//   idx   : chosen index (0 when valid is low)
// ----------------------------------------------------------------------------
import usbf_dma_pkg::*;

module usbf_rr_pick #(
    parameter int NUM_EP = DEF_NUM_EP,
    parameter int EPW    = DEF_EPW
) (
    input  logic [NUM_EP-1:0] req,
    input  logic [EPW-1:0]    ptr,
    output logic              valid,
    output logic [EPW-1:0]    idx
);

    // hit[k] means "the endpoint k+1 places above ptr is requesting";
    // cand[k] is that endpoint's index after wrapping.
    logic [NUM_EP-1:0] hit;
    logic [EPW-1:0]    cand [NUM_EP];

    for (genvar gi = 0; gi < NUM_EP; gi++) begin : g_cand
        localparam int OFS = gi + 1;
        int raw;
        assign raw      = int'(ptr) + OFS;
        assign cand[gi] = EPW'((raw >= NUM_EP) ? raw - NUM_EP : raw);
        assign hit[gi]  = req[cand[gi]];
    end

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        valid = |hit;
        idx   = '0;
        for (int k = NUM_EP - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/usbf_dma_arb.sv
// ----------------------------------------------------------------------------
// usbf_dma_arb
// DMA request arbiter / acknowledge generator (wishbone clock side of the
// USB function core). Grants one endpoint at a time to the system DMA
// controller, issues one word request per grant step and returns a single
// cycle dma_ack to the owning endpoint for each completed word. An endpoint
// keeps the grant for up to BURST_MAX words while it still requests.
//
// Ports:
//   wclk : clock
//   rst  : asynchronous active-high reset
//   bus  : usbf_dma_arb_if.master (arb_en, dma_req, dma_ack, xfer_req,
//          xfer_ep, xfer_ack, dma_busy, to_clr, to_err)
//
// Build option:
//   USBF_DMA_ARB_TO_EN : when defined, a transfer that gets no xfer_ack
//   within TO_CYC cycles is abandoned (no dma_ack) and the sticky to_err
//   flag is set; to_clr clears it. Undefined: XFER waits forever, to_err=0.
// ----------------------------------------------------------------------------
import usbf_dma_pkg::*;

module usbf_dma_arb #(
    parameter int NUM_EP    = DEF_NUM_EP,
    parameter int EPW       = DEF_EPW,
    parameter int BURST_MAX = DEF_BURST_MAX,
    parameter int TO_CYC    = DEF_TO_CYC
) (
    input  logic           wclk,
    input  logic           rst,
    usbf_dma_arb_if.master bus
);

    state_t         state_reg;
    state_t         state_next;
    logic [EPW-1:0] rr_ptr_reg;
    logic [EPW-1:0] grant_reg;
    logic [3:0]     word_cnt_reg;

    logic           pick_valid;
    logic [EPW-1:0] pick_idx;
    logic           start_grant;
    logic           burst_again;
    logic           word_done;
    logic           to_hit;

    usbf_rr_pick #(
        .NUM_EP (NUM_EP),
        .EPW    (EPW)
    ) u_pick (
        .req   (bus.dma_req),
        .ptr   (rr_ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign start_grant = (state_reg == IDLE) && bus.arb_en && pick_valid;
    assign word_done   = (state_reg == XFER) && bus.xfer_ack;
    // By GAP2 the endpoint has had a cycle to drop its request after dma_ack,
    // so a still-high request really asks for another word.
    assign burst_again = (state_reg == GAP2) && bus.dma_req[grant_reg] &&
                         bus.arb_en && (int'(word_cnt_reg) < BURST_MAX);

`ifdef USBF_DMA_ARB_TO_EN
    localparam int TW = to_width(TO_CYC);

    logic [TW-1:0] to_cnt_reg;
    logic          to_err_reg;

    // Counter is held at zero outside XFER, so every XFER entry starts at 0.
    // An ack in the limit cycle takes precedence over the timeout.
    assign to_hit = (state_reg == XFER) && !bus.xfer_ack &&
                    (to_cnt_reg == TW'(TO_CYC - 1));

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            to_cnt_reg <= '0;
        end else if (state_reg != XFER) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + TW'(1);
        end
    end

    // Set has priority over a simultaneous clear.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            to_err_reg <= 1'b0;
        end else if (to_hit) begin
            to_err_reg <= 1'b1;
        end else if (bus.to_clr) begin
            to_err_reg <= 1'b0;
        end
    end

    assign bus.to_err = to_err_reg;
`else
    logic     unused_to_clr;
    localparam int unused_to_cyc = TO_CYC;

    assign to_hit        = 1'b0;
    assign bus.to_err    = 1'b0;
    assign unused_to_clr = bus.to_clr;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start_grant) state_next = XFER;
            XFER: begin
                if (bus.xfer_ack) begin
                    state_next = GAP1;
                end else if (to_hit) begin
                    state_next = IDLE;
                end
            end
            GAP1: state_next = GAP2;
            GAP2: state_next = burst_again ? XFER : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- grant / burst bookkeeping ----------------
    // rr_ptr takes the new grant immediately, so whether the burst ends
    // normally or by timeout the next search begins just past this endpoint.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg   <= EPW'(NUM_EP - 1);
            grant_reg    <= '0;
            word_cnt_reg <= '0;
        end else begin
            if (start_grant) begin
                rr_ptr_reg   <= pick_idx;
                grant_reg    <= pick_idx;
                word_cnt_reg <= '0;
            end else if (word_done) begin
                word_cnt_reg <= word_cnt_reg + 4'd1;
            end
        end
    end

    // ---------------- outputs ----------------
    // dma_ack is decoded from GAP1, which is entered only from XFER on
    // xfer_ack, so it is a registered one-cycle pulse and can never repeat
    // in back-to-back cycles.
    always_comb begin
        bus.xfer_req = (state_reg == XFER);
        bus.xfer_ep  = grant_reg;
        bus.dma_busy = (state_reg != IDLE);
        bus.dma_ack  = '0;
        if (state_reg == GAP1) begin
            bus.dma_ack[grant_reg] = 1'b1;
        end
    end

endmodule

// File: tb/tb_usbf_dma_arb.sv
import usbf_dma_pkg::*;

module tb_usbf_dma_arb;

    logic wclk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   last_a = 15;
    int   last_b = 15;

    usbf_dma_arb_if #(.NUM_EP(16), .EPW(4)) ia ();
    usbf_dma_arb_if #(.NUM_EP(16), .EPW(4)) ib ();

    // A: burst of 4, short timeout (when built). B: burst of 1.
    usbf_dma_arb #(.NUM_EP(16), .EPW(4), .BURST_MAX(4), .TO_CYC(8)) u_dut_a (
        .wclk (wclk),
        .rst  (rst),
        .bus  (ia)
    );

    usbf_dma_arb #(.NUM_EP(16), .EPW(4), .BURST_MAX(1), .TO_CYC(1024)) u_dut_b (
        .wclk (wclk),
        .rst  (rst),
        .bus  (ib)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;
    always @(posedge wclk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- bus access helpers ----------------
    function automatic logic xreq(input bit sel);
        return sel ? ib.xfer_req : ia.xfer_req;
    endfunction
    function automatic logic [3:0] xep(input bit sel);
        return sel ? ib.xfer_ep : ia.xfer_ep;
    endfunction
    function automatic logic [15:0] dack(input bit sel);
        return sel ? ib.dma_ack : ia.dma_ack;
    endfunction
    function automatic logic busy(input bit sel);
        return sel ? ib.dma_busy : ia.dma_busy;
    endfunction
    task automatic set_req(input bit sel, input logic [15:0] m);
        if (sel) ib.dma_req = m; else ia.dma_req = m;
    endtask
    task automatic set_en(input bit sel, input logic v);
        if (sel) ib.arb_en = v; else ia.arb_en = v;
    endtask
    task automatic set_ack(input bit sel, input logic v);
        if (sel) ib.xfer_ack = v; else ia.xfer_ack = v;
    endtask

    // Reference round-robin: first requester strictly after 'last', wrapping.
    function automatic int pick(input logic [15:0] m, input int last);
        int j;
        for (int k = 1; k <= 16; k++) begin
            j = (last + k) % 16;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [15:0] rnd_mask();
        logic [15:0] m;
        m = 16'($urandom) & 16'($urandom);
        if (m == 16'h0) m = 16'(1) << $urandom_range(0, 15);
        return m;
    endfunction

    // ---------------- DMA-controller side drivers ----------------
    task automatic wait_xreq(input bit sel, output int wt, output bit ok);
        ok = 1'b0;
        wt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge wclk);
            wt++;
            if (xreq(sel) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack_word(input bit sel, input int dly, output logic [15:0] ackv, output int at);
        repeat (dly) @(negedge wclk);
        set_ack(sel, 1'b1);
        @(negedge wclk);
        ackv = dack(sel);
        at   = cyc;
        set_ack(sel, 1'b0);
    endtask

    task automatic serve(input bit sel, input int dly, output int ep, output logic [15:0] ackv,
                         output int wt, output int at, output bit ok);
        wait_xreq(sel, wt, ok);
        ep   = -1;
        ackv = '0;
        at   = 0;
        if (ok) begin
            ep = int'(xep(sel));
            ack_word(sel, dly, ackv, at);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        ia.arb_en = 1'b0; ia.dma_req = '0; ia.xfer_ack = 1'b0; ia.to_clr = 1'b0;
        ib.arb_en = 1'b0; ib.dma_req = '0; ib.xfer_ack = 1'b0; ib.to_clr = 1'b0;
        repeat (3) @(negedge wclk);
        checks++;
        if ({ia.xfer_req, ia.xfer_ep, ia.dma_ack, ia.dma_busy, ia.to_err} !== 23'h0) begin
            errors++;
            $display("FAIL reset_a: got req=%0b ep=%0d ack=%h busy=%0b to_err=%0b required all 0",
                     ia.xfer_req, ia.xfer_ep, ia.dma_ack, ia.dma_busy, ia.to_err);
        end
        checks++;
        if ({ib.xfer_req, ib.xfer_ep, ib.dma_ack, ib.dma_busy, ib.to_err} !== 23'h0) begin
            errors++;
            $display("FAIL reset_b: got req=%0b ep=%0d ack=%h busy=%0b required all 0",
                     ib.xfer_req, ib.xfer_ep, ib.dma_ack, ib.dma_busy);
        end
        rst = 1'b0;
        @(negedge wclk);
        checks++;
        if (ia.dma_busy !== 1'b0 || ia.xfer_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%0b req=%0b required 0 0", ia.dma_busy, ia.xfer_req);
        end
        $display("reset done");
    endtask

    task automatic test_random(input bit sel, input int burst, input int nwords, inout int last);
        logic [15:0] m, ackv;
        int exp, cur, ep, wt, at, ew, words;
        bit cont, ok;
        set_en(sel, 1'b1);
        m = rnd_mask();
        set_req(sel, m);
        cont = 1'b0; cur = 0; words = 0; ew = 1;
        for (int w = 0; w < nwords; w++) begin
            exp = cont ? cur : pick(m, last);
            serve(sel, $urandom_range(0, 3), ep, ackv, wt, at, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rand_wait: sel=%0d no xfer_req within 40 cycles, required one", sel);
            end
            checks++;
            if (ep !== exp) begin
                errors++;
                $display("FAIL rand_ep: sel=%0d word %0d got ep %0d required %0d", sel, w, ep, exp);
            end
            checks++;
            if (ackv !== (16'(1) << exp)) begin
                errors++;
                $display("FAIL rand_ack: sel=%0d got dma_ack %h required %h", sel, ackv, 16'(1) << exp);
            end
            checks++;
            if (wt !== ew) begin
                errors++;
                $display("FAIL rand_lat: sel=%0d got %0d cycles to xfer_req required %0d", sel, wt, ew);
            end
            $display("word sel=%0d n=%0d mask=%h ep=%0d lat=%0d", sel, w, m, ep, wt);
            if (!cont) begin
                last  = exp;
                words = 0;
            end
            cur = exp;
            words++;
            m = ($urandom_range(0, 9) == 0 || w == nwords - 1) ? 16'h0 : rnd_mask();
            set_req(sel, m);
            cont = m[exp] && (words < burst);
            if (cont) begin
                ew = 2;
            end else if (m != 16'h0) begin
                ew = 3;
            end else begin
                repeat (3) @(negedge wclk);
                checks++;
                if (busy(sel) !== 1'b0 || xreq(sel) !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_idle: sel=%0d got busy=%0b req=%0b required 0 0",
                             sel, busy(sel), xreq(sel));
                end
                if (w != nwords - 1) begin
                    m = rnd_mask();
                    set_req(sel, m);
                end
                ew = 1;
            end
        end
    endtask

    task automatic test_round_robin;
        int exp_rr [6] = '{0, 4, 8, 0, 4, 8};
        logic [15:0] ackv;
        int ep, wt, at;
        bit ok;
        set_en(1, 1'b1);
        set_req(1, 16'h0111);
        for (int i = 0; i < 6; i++) begin
            serve(1, 1, ep, ackv, wt, at, ok);
            checks++;
            if (ep !== exp_rr[i]) begin
                errors++;
                $display("FAIL rr_order: grant %0d got ep %0d required %0d", i, ep, exp_rr[i]);
            end
            checks++;
            if (ackv !== (16'(1) << exp_rr[i])) begin
                errors++;
                $display("FAIL rr_ack: got %h required %h", ackv, 16'(1) << exp_rr[i]);
            end
            $display("word rr n=%0d ep=%0d", i, ep);
        end
        set_req(1, 16'h0);
        repeat (3) @(negedge wclk);
        last_b = 8;
    endtask

    task automatic test_single;
        logic [15:0] ackv;
        int ep, wt, at, prev;
        bit ok;
        set_en(0, 1'b1);
        set_req(0, 16'h0008);
        prev = 0;
        for (int w = 0; w < 4; w++) begin
            serve(0, 2, ep, ackv, wt, at, ok);
            checks++;
            if (ep !== 3 || ackv !== 16'h0008) begin
                errors++;
                $display("FAIL single_word: got ep %0d ack %h required 3 0008", ep, ackv);
            end
            if (w > 0) begin
                checks++;
                if (at - prev < 4) begin
                    errors++;
                    $display("FAIL single_period: got %0d cycles between acks required >=4", at - prev);
                end
            end
            prev = at;
            $display("word single n=%0d ep=%0d at=%0d", w, ep, at);
        end
        @(negedge wclk);
        @(negedge wclk);
        checks++;
        if (busy(0) !== 1'b0 || xreq(0) !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%0b req=%0b required 0 0 after burst", busy(0), xreq(0));
        end
        serve(0, 2, ep, ackv, wt, at, ok);
        checks++;
        if (ep !== 3 || wt !== 1) begin
            errors++;
            $display("FAIL single_regrant: got ep %0d lat %0d required 3 1", ep, wt);
        end
        set_req(0, 16'h0);
        repeat (3) @(negedge wclk);
    endtask

    task automatic test_release;
        logic [15:0] ackv;
        int ep, wt, at, acks;
        bit ok;
        set_en(0, 1'b1);
        set_req(0, 16'h0020);
        serve(0, 0, ep, ackv, wt, at, ok);
        set_req(0, 16'h0);
        acks = (ackv === 16'h0020) ? 1 : 0;
        @(negedge wclk);
        @(negedge wclk);
        checks++;
        if (busy(0) !== 1'b0 || xreq(0) !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: got busy=%0b req=%0b required 0 0", busy(0), xreq(0));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge wclk);
            if (dack(0) !== 16'h0) acks++;
        end
        checks++;
        if (acks !== 1 || ep !== 5) begin
            errors++;
            $display("FAIL release_acks: got %0d acks ep %0d required 1 ep 5", acks, ep);
        end
        $display("word release ep=%0d", ep);
    endtask

    task automatic test_stray_and_disable;
        logic [15:0] ackv;
        int wt, at, seen;
        bit ok;
        set_en(0, 1'b1);
        set_req(0, 16'h0);
        set_ack(0, 1'b1);
        @(negedge wclk);
        set_ack(0, 1'b0);
        checks++;
        if (dack(0) !== 16'h0 || busy(0) !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: got ack %h busy %0b required 0000 0", dack(0), busy(0));
        end
        @(negedge wclk);
        checks++;
        if (dack(0) !== 16'h0) begin
            errors++;
            $display("FAIL stray_ack2: got ack %h required 0000", dack(0));
        end
        set_req(0, 16'h0004);
        wait_xreq(0, wt, ok);
        checks++;
        if (!ok || xep(0) !== 4'd2) begin
            errors++;
            $display("FAIL disable_grant: got ok=%0b ep %0d required 1 2", ok, xep(0));
        end
        set_en(0, 1'b0);
        ack_word(0, 1, ackv, at);
        checks++;
        if (ackv !== 16'h0004) begin
            errors++;
            $display("FAIL disable_ack: got %h required 0004", ackv);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge wclk);
            if (xreq(0) !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0 || busy(0) !== 1'b0) begin
            errors++;
            $display("FAIL disable_hold: got %0d xfer_req cycles busy %0b required 0 0", seen, busy(0));
        end
        set_req(0, 16'h0);
        set_en(0, 1'b1);
        $display("word disable ep=2 ack=%h", ackv);
    endtask

    task automatic test_timeout;
`ifdef USBF_DMA_ARB_TO_EN
        logic [15:0] ackv;
        int wt, n, acks;
        bit ok;
        set_en(0, 1'b1);
        set_req(0, 16'h0002);
        wait_xreq(0, wt, ok);
        set_req(0, 16'h0);
        n = ok ? 1 : 0;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge wclk);
            if (dack(0) !== 16'h0) acks++;
            if (xreq(0) === 1'b1) n++;
            else break;
        end
        checks++;
        if (n !== 8 || acks !== 0) begin
            errors++;
            $display("FAIL to_len: got %0d XFER cycles %0d acks required 8 0", n, acks);
        end
        checks++;
        if (ia.to_err !== 1'b1 || busy(0) !== 1'b0) begin
            errors++;
            $display("FAIL to_set: got to_err %0b busy %0b required 1 0", ia.to_err, busy(0));
        end
        ia.to_clr = 1'b1;
        @(negedge wclk);
        ia.to_clr = 1'b0;
        checks++;
        if (ia.to_err !== 1'b0) begin
            errors++;
            $display("FAIL to_clr: got to_err %0b required 0", ia.to_err);
        end
        set_req(0, 16'h0002);
        wait_xreq(0, wt, ok);
        set_req(0, 16'h0);
        repeat (7) @(negedge wclk);
        checks++;
        if (xreq(0) !== 1'b1) begin
            errors++;
            $display("FAIL to_limit_req: got xfer_req %0b in 8th cycle required 1", xreq(0));
        end
        set_ack(0, 1'b1);
        @(negedge wclk);
        ackv = dack(0);
        set_ack(0, 1'b0);
        checks++;
        if (ackv !== 16'h0002 || ia.to_err !== 1'b0) begin
            errors++;
            $display("FAIL to_limit_ack: got ack %h to_err %0b required 0002 0", ackv, ia.to_err);
        end
        repeat (3) @(negedge wclk);
        $display("word timeout checks done");
`else
        $display("timeout feature not built");
`endif
    endtask

    task automatic test_reset_mid_xfer;
        logic [15:0] ackv;
        int wt, at;
        bit ok, found;
        set_en(0, 1'b1);
        set_req(0, 16'h0c24);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            wait_xreq(0, wt, ok);
            if (ok && xep(0) !== 4'd2) found = 1'b1;
            else ack_word(0, 0, ackv, at);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ia.xfer_req, ia.xfer_ep, ia.dma_ack, ia.dma_busy, ia.to_err} !== 23'h0 || !found) begin
            errors++;
            $display("FAIL rst_mid: got req=%0b ep=%0d ack=%h busy=%0b found=%0b required all 0, found 1",
                     ia.xfer_req, ia.xfer_ep, ia.dma_ack, ia.dma_busy, found);
        end
        @(negedge wclk);
        checks++;
        if (ia.dma_ack !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_ack: got %h required 0000", ia.dma_ack);
        end
        rst = 1'b0;
        wait_xreq(0, wt, ok);
        checks++;
        if (!ok || xep(0) !== 4'd2 || wt !== 1) begin
            errors++;
            $display("FAIL rst_regrant: got ok=%0b ep=%0d lat=%0d required 1 2 1", ok, xep(0), wt);
        end
        set_req(0, 16'h0);
        ack_word(0, 0, ackv, at);
        $display("word reset_mid regrant ep=%0d", xep(0));
        repeat (3) @(negedge wclk);
    endtask

    initial begin
        test_reset();
        test_random(0, 4, 40, last_a);
        test_round_robin();
        test_random(1, 1, 30, last_b);
        test_single();
        test_release();
        test_stray_and_disable();
        test_timeout();
        test_reset_mid_xfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
